// File: rtl/pp_avalon_arbiter.sv
// Two-requester round-robin arbiter in front of the parallel port's
// Avalon-MM register slave. One transaction is in flight at a time. The
// downstream slave never stalls and returns read data a fixed number of
// cycles after the read strobe.
module pp_avalon_arbiter #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,

    output logic              s_chipselect,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Counter value seen in the last WAIT cycle, i.e. the cycle in which
    // s_readdata is valid (READ_LATENCY cycles after the ISSUE cycle).
    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

    state_t            state;
    logic              rr_last;
    logic              op_write;
    logic [2:0]        lat_cnt;

    logic              req0;
    logic              req1;
    logic              grant;
    logic              grant_write;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    // Request decode and round-robin choice used when the FSM is idle;
    // a read+write request counts as a write.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~rr_last;
        end else if (req1) begin
            grant = 1'b1;
        end
        grant_write = grant ? m1_write     : m0_write;
        grant_addr  = grant ? m1_address   : m0_address;
        grant_wdata = grant ? m1_writedata : m0_writedata;
    end

    // Transaction FSM; every output is a register so nothing from mX_* reaches s_* combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            owner          <= 1'b0;
            rr_last        <= 1'b1;
            op_write       <= 1'b0;
            lat_cnt        <= '0;
            s_chipselect   <= 1'b0;
            s_read         <= 1'b0;
            s_write        <= 1'b0;
            s_address      <= '0;
            s_writedata    <= '0;
            m0_readdata    <= '0;
            m1_readdata    <= '0;
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
        end else begin
            // Strobes and the waitrequest release are single-cycle pulses.
            s_chipselect   <= 1'b0;
            s_read         <= 1'b0;
            s_write        <= 1'b0;
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state        <= ISSUE;
                        busy         <= 1'b1;
                        owner        <= grant;
                        rr_last      <= grant;
                        op_write     <= grant_write;
                        s_address    <= grant_addr;
                        s_writedata  <= grant_wdata;
                        s_chipselect <= 1'b1;
                        s_read       <= ~grant_write;
                        s_write      <= grant_write;
                    end
                end

                ISSUE: begin
                    if (op_write) begin
                        state <= DONE;
                        if (owner) begin
                            m1_waitrequest <= 1'b0;
                        end else begin
                            m0_waitrequest <= 1'b0;
                        end
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= '0;
                    end
                end

                WAIT: begin
                    if (lat_cnt == LAST_CNT) begin
                        state <= DONE;
                        if (owner) begin
                            m1_readdata    <= s_readdata;
                            m1_waitrequest <= 1'b0;
                        end else begin
                            m0_readdata    <= s_readdata;
                            m0_waitrequest <= 1'b0;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
